// File: rtl/xy_change_logger_pkg.sv
// Shared definitions for the x/y change logger.
// A logged entry packs {ts, x, y}: x/y occupy the two LSBs and the
// timestamp sits directly above them.
package xy_change_logger_pkg;

    localparam int unsigned XYL_XY_LSB = 0;
    localparam int unsigned XYL_XY_W   = 2;
    localparam int unsigned XYL_TS_LSB = XYL_XY_LSB + XYL_XY_W;

    // Entry width for a given timestamp width.
    function automatic int unsigned xyl_entry_w(input int unsigned ts_w);
        return ts_w + XYL_XY_W;
    endfunction

endpackage

// File: rtl/xy_change_logger_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, for the x/y change logger.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   i_push       write i_data (accepted when not full, or full with a pop)
//   i_pop        drop head entry (ignored while empty)
//   i_data       entry to write
//   o_data       head entry (registered storage, no path from inputs)
//   o_full       DEPTH entries held
//   o_empty      no entries held
//   o_level      occupancy, 0..DEPTH
module xy_change_logger_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_empty   = (w_level == '0);
    assign o_full    = (w_level == FULL_LVL);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: the read side is masked by the empty flag.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/xy_change_logger.sv
// Clocked change observer for the x/y signal pair.
// Samples {x,y} every clock, logs {timestamp, x, y} on change (and on the
// first enabled cycle) into a FIFO drained through a valid/ready port.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           capture enable
//   x, y         observed signals, synchronous to clk
//   clr_ovf      clears overflow and drop_cnt (a same-cycle drop wins)
//   out_valid    head entry valid
//   out_ready    consumer accepts head
//   out_ts       head timestamp (0 while empty)
//   out_xy       head {x,y} (0 while empty)
//   level        FIFO occupancy
//   overflow     sticky: an event was dropped
//   drop_cnt     saturating dropped-event count
module xy_change_logger
    import xy_change_logger_pkg::*;
#(
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    x,
    input  logic                    y,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TS_W-1:0]         out_ts,
    output logic [1:0]              out_xy,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam int unsigned ENTRY_W = xyl_entry_w(TS_W);

    logic [TS_W-1:0]    r_ts;
    logic [1:0]         r_prev_xy;
    logic               r_arm;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_cnt;

    logic [1:0]         w_xy;
    logic               w_ev;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_xy    = {x, y};
    assign w_ev    = en & (r_arm | (w_xy != r_prev_xy));
    assign w_pop   = out_valid & out_ready;
    assign w_drop  = w_ev & w_full & ~w_pop;
    assign w_entry = {r_ts, w_xy};

    xy_change_logger_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ev),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign out_valid = ~w_empty;
    assign out_ts    = out_valid ? w_head[XYL_TS_LSB +: TS_W]     : '0;
    assign out_xy    = out_valid ? w_head[XYL_XY_LSB +: XYL_XY_W] : '0;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts       <= '0;
            r_prev_xy  <= '0;
            r_arm      <= 1'b1;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ts      <= r_ts + TS_W'(1);
            r_prev_xy <= w_xy;
            // Re-armed while disabled so the first enabled cycle always logs.
            r_arm     <= ~en;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clr_ovf)
                    r_drop_cnt <= DROP_W'(1);
                else if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_xy_change_logger.sv
module tb_xy_change_logger;

    localparam int unsigned TS_W   = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int          DROP_MAX = (1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, x = 1'b0, y = 1'b0, clr_ovf = 1'b0, out_ready = 1'b0;
    logic              out_valid;
    logic [TS_W-1:0]   out_ts;
    logic [1:0]        out_xy;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xy_change_logger #(
        .TS_W   (TS_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .x         (x),
        .y         (y),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_xy    (out_xy),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // Reference model: a queue of logged entries plus the observer state.
    logic [TS_W+1:0] m_q [$];
    int              m_ts;
    logic [1:0]      m_prev;
    bit              m_arm;
    bit              m_ovf;
    int              m_drop;

    task automatic model_reset();
        m_q.delete();
        m_ts = 0; m_prev = 2'b00; m_arm = 1'b1; m_ovf = 1'b0; m_drop = 0;
    endtask

    task automatic model_edge();
        bit pop, ev, full;
        pop  = (m_q.size() > 0) && out_ready;
        ev   = en && (m_arm || ({x, y} != m_prev));
        full = (m_q.size() == DEPTH);
        if (pop) void'(m_q.pop_front());
        if (ev && full && !pop) begin
            m_ovf  = 1'b1;
            m_drop = clr_ovf ? 1 : ((m_drop < DROP_MAX) ? m_drop + 1 : DROP_MAX);
        end else begin
            if (ev) m_q.push_back({TS_W'(m_ts), x, y});
            if (clr_ovf) begin m_ovf = 1'b0; m_drop = 0; end
        end
        m_ts   = (m_ts + 1) % (1 << TS_W);
        m_prev = {x, y};
        m_arm  = !en;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [TS_W+1:0] head;
        bit v;
        v    = (m_q.size() > 0);
        head = v ? m_q[0] : '0;
        chk({tag, ".valid"},    32'(out_valid), 32'(v));
        chk({tag, ".ts"},       32'(out_ts),    32'(head[TS_W+1:2]));
        chk({tag, ".xy"},       32'(out_xy),    32'(head[1:0]));
        chk({tag, ".level"},    32'(level),     32'(m_q.size()));
        chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt),  32'(m_drop));
    endtask

    task automatic step(input logic a_en, input logic a_x, input logic a_y,
                        input logic a_rdy, input logic a_clr, input string tag);
        en = a_en; x = a_x; y = a_y; out_ready = a_rdy; clr_ovf = a_clr;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic       en, x, y, rdy;
        logic       e_v;
        int         e_ts;
        logic [1:0] e_xy;
        int         e_lvl;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cx;
        //            en  x  y  rdy  v   ts  xy     lvl
        tbl[0]  = '{1'b1,1'b0,1'b1,1'b0, 1'b1, 0, 2'b01, 1};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0, 0, 2'b00, 0};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0, 0, 2'b00, 0};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0, 0, 2'b00, 0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b1, 1'b0, 0, 2'b00, 0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1, 5, 2'b10, 1};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0, 0, 2'b00, 0};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0, 0, 2'b00, 0};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0, 0, 2'b00, 0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0, 0, 2'b00, 0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0, 0, 2'b00, 0};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0, 1'b1, 11, 2'b01, 1};
        tbl[12] = '{1'b1,1'b0,1'b1,1'b0, 1'b1, 11, 2'b01, 1};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b1, 1'b0, 0, 2'b00, 0};

        model_reset();
        en = 1'b1; x = 1'b0; y = 1'b1;
        #12;
        check_model("reset");
        rst_n = 1'b1;

        // First entry, static inputs, change at ts=5, enable gating.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].x, tbl[i].y, tbl[i].rdy, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.v", i),   32'(out_valid), 32'(tbl[i].e_v));
            chk($sformatf("tbl%0d.ts", i),  32'(out_ts),    32'(tbl[i].e_ts));
            chk($sformatf("tbl%0d.xy", i),  32'(out_xy),    32'(tbl[i].e_xy));
            chk($sformatf("tbl%0d.lvl", i), 32'(level),     32'(tbl[i].e_lvl));
        end

        // Fill past full: 12 toggles -> 8 stored, 4 dropped.
        cx = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cx = ~cx;
            step(1'b1, cx, 1'b1, 1'b0, 1'b0, "fill");
        end
        chk("fill.level", 32'(level), 32'(DEPTH));
        chk("fill.overflow", 32'(overflow), 32'd1);
        chk("fill.drop_cnt", 32'(drop_cnt), 32'd4);
        step(1'b1, cx, 1'b1, 1'b0, 1'b1, "clr");
        chk("clr.drop_cnt", 32'(drop_cnt), 32'd0);
        chk("clr.overflow", 32'(overflow), 32'd0);

        // Full with simultaneous pop and event: no drop, level stays at DEPTH.
        for (int i = 0; i < 3; i++) begin
            cx = ~cx;
            step(1'b1, cx, 1'b1, 1'b1, 1'b0, "fullpp");
            chk("fullpp.level", 32'(level), 32'(DEPTH));
            chk("fullpp.drop_cnt", 32'(drop_cnt), 32'd0);
        end

        // Clear and drop in the same cycle: the drop wins.
        cx = ~cx;
        step(1'b1, cx, 1'b1, 1'b0, 1'b1, "clrdrop");
        chk("clrdrop.overflow", 32'(overflow), 32'd1);
        chk("clrdrop.drop_cnt", 32'(drop_cnt), 32'd1);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) begin
            cx = ~cx;
            step(1'b1, cx, 1'b1, 1'b0, 1'b0, "sat");
        end
        chk("sat.drop_cnt", 32'(drop_cnt), 32'(DROP_MAX));
        step(1'b1, cx, 1'b1, 1'b0, 1'b1, "satclr");

        // Drain, queue three entries, then reset mid-cycle.
        for (int i = 0; i < 10; i++) step(1'b1, cx, 1'b1, 1'b1, 1'b0, "drain");
        chk("drain.level", 32'(level), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cx = ~cx;
            step(1'b1, cx, 1'b1, 1'b0, 1'b0, "q3");
        end
        chk("q3.level", 32'(level), 32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        @(posedge clk);
        #1;
        check_model("rsthold");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, cx, 1'b1, 1'b0, 1'b0, "postrst");
        chk("postrst.valid", 32'(out_valid), 32'd1);
        chk("postrst.ts", 32'(out_ts), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic r_en, r_x, r_y, r_rdy, r_clr;
            r_en  = ($urandom_range(0, 7) != 0);
            r_x   = ($urandom_range(0, 2) == 0) ? ~x : x;
            r_y   = ($urandom_range(0, 3) == 0) ? ~y : y;
            r_rdy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 31) == 0);
            step(r_en, r_x, r_y, r_rdy, r_clr, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
